// File: rtl/my_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_serial_adder_if
//  Description : Handshake/data bundle for my_serial_adder.
//                Input side : in_valid / in_ready, operands a, b, carry-in cin.
//                Output side: out_valid / out_ready, result sum, carry-out co,
//                             busy status, and ovf when SERIAL_ADDER_OVF_EN
//                             is defined.
//                Modport slave  : the adder.
//                Modport master : the producer/consumer driving the adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface my_serial_adder_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport slave (
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, co, busy
    );

    modport master (
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, co, busy
    );
endinterface
`default_nettype wire

// File: rtl/my_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : my_serial_adder
//  Description : Bit-serial adder, LSB first, one full-add per clock.
//                Computes a + b + cin (mod 2^WIDTH) with carry-out co.
//                Ports : clk, rst (async, active-high), bus (slave modport of
//                        my_serial_adder_if: in_valid/in_ready, a, b, cin,
//                        out_valid/out_ready, sum, co, busy [, ovf]).
//                Option: SERIAL_ADDER_OVF_EN adds the signed-overflow output
//                        ovf (carry into MSB XOR carry-out).
//                Timing: out_valid rises WIDTH cycles after the input
//                        handshake; a new operand set is accepted one cycle
//                        after the output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module my_serial_adder #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    my_serial_adder_if.slave   bus
);
    // Wide enough to hold WIDTH itself, so the count never wraps mid-operation.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             co_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             w_bit;
    logic             w_carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             cmsb_q;
`endif

    // Operands shift right, so the current bit is always at position 0.
    assign w_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // Drop the new sum bit into the position selected by the counter.
    always_comb begin
        sum_d = sum_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) begin
                sum_d[i] = w_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready is high exactly in IDLE, so in_valid alone
                    // completes the handshake here.
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        co_q       <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        cmsb_q     <= 1'b0;
`endif
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= w_carry;
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry flop currently holds the carry into the MSB.
                        cmsb_q      <= carry_q;
`endif
                        co_q        <= w_carry;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // No accept in this cycle: in_ready rises only once
                    // IDLE has been re-entered.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = cmsb_q ^ co_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_my_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_serial_adder
//  Description : Self-checking bench for my_serial_adder (WIDTH = 5).
//                A transaction-level model predicts in_ready, busy,
//                out_valid, sum, co (and ovf) every cycle; directed tests
//                pin the model with hand-computed literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_my_serial_adder;
    localparam int WIDTH = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    my_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    my_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    int               cyc = 0;
    bit               have_op = 1'b0;
    int               op_hs = 0;
    logic [WIDTH:0]   m_tot;
    logic [WIDTH-1:0] m_sum;
    logic             m_co;
    logic             m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_op = 1'b0;
        end else begin
            cyc++;
            if (have_op) begin
                if (cyc > op_hs + WIDTH && bus.out_ready) have_op = 1'b0;
            end else if (bus.in_valid) begin
                m_tot   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                m_sum   = m_tot[WIDTH-1:0];
                m_co    = m_tot[WIDTH];
                m_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (m_sum[WIDTH-1] != bus.a[WIDTH-1]);
                have_op = 1'b1;
                op_hs   = cyc;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int  dut_results = 0;
    logic exp_ov;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy",      bus.busy,      0);
            chk("rst_sum",       bus.sum,       0);
            chk("rst_co",        bus.co,        0);
        end else begin
            exp_ov = have_op && (cyc >= op_hs + WIDTH);
            chk("in_ready",  bus.in_ready,  !have_op);
            chk("busy",      bus.busy,      have_op && (cyc < op_hs + WIDTH));
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("sum", bus.sum, m_sum);
                chk("co",  bus.co,  m_co);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", bus.ovf, m_ovf);
`endif
            end
            if (bus.out_valid && bus.out_ready) dut_results++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2 with the DUT idle and out_ready = 1.
    task automatic run_op(input int a, input int b, input int ci,
                          input int es, input int ec, input int eovf, input string nm);
        int n;
        bus.a = WIDTH'(a); bus.b = WIDTH'(b); bus.cin = ci[0];
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, n, WIDTH);
        chk({nm, "_sum"}, bus.sum, es);
        chk({nm, "_co"},  bus.co,  ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({nm, "_ovf"}, bus.ovf, eovf);
`else
        if (eovf > 1) $display("note: bad ovf arg");
`endif
        step();
        chk({nm, "_pulse"},    bus.out_valid, 0);
        chk({nm, "_ready"},    bus.in_ready,  1);
    endtask

    initial begin
        int n, last_hs, hs;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        // Accept on the first edge after reset release.
        run_op(13, 9, 0, 22, 0, 0, "t13p9");
        run_op(31, 1, 1, 1, 1, 0, "t31p1c");
        run_op(15, 1, 0, 16, 0, 1, "t15p1");
        run_op(0, 0, 0, 0, 0, 0, "tzero");
        run_op(31, 31, 1, 31, 1, 0, "tmax");
        run_op(16, 16, 0, 0, 1, 1, "tmsb");

        // Stall in DONE with input noise.
        bus.out_ready = 1'b0;
        bus.a = 5'd3; bus.b = 5'd4; bus.cin = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin step(); n++; end
        chk("stall_latency", n, WIDTH);
        for (int i = 0; i < 10; i++) begin
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
            bus.in_valid = i[0];
            step();
        end
        chk("stall_sum", bus.sum, 7);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        chk("stall_release_ready", bus.in_ready, 1);
        chk("stall_release_valid", bus.out_valid, 0);

        // Reset during RUN cycle 3 aborts the operation.
        bus.a = 5'd7; bus.b = 5'd8; bus.cin = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) n++;
        end
        chk("abort_no_valid", n, 0);
        chk("abort_ready", bus.in_ready, 1);
        run_op(2, 3, 0, 5, 0, 0, "t2p3");

        // Back-to-back with in_valid held high.
        dut_results = 0;
        last_hs = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            n = 0;
            while (!bus.in_ready && n < 50) begin step(); n++; end
            chk("b2b_wait", (n < 50), 1);
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
            step();
            hs = cyc;
            if (k == 99) bus.in_valid = 1'b0;
            if (k > 0) chk("b2b_period", hs - last_hs, WIDTH + 2);
            last_hs = hs;
        end
        repeat (12) step();
        chk("b2b_count", dut_results, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/my_serial_adder.md
MY_SERIAL_ADDER -- requirements
Module: my_serial_adder

Interface
REQ-001 Parameter: WIDTH, 5, operand/result width in bits (legal 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block can accept an operand set.
REQ-006 Port: a  input  WIDTH  operand A, unsigned, sampled on input handshake.
REQ-007 Port: b  input  WIDTH  operand B, unsigned, sampled on input handshake.
REQ-008 Port: cin  input  1  carry-in, sampled on input handshake.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: sum  output  WIDTH  result bits, a+b+cin modulo 2^WIDTH.
REQ-012 Port: co  output  1  carry-out of the WIDTH-bit addition.
REQ-013 Port: busy  output  1  high in RUN state.

Function
REQ-014 Block SHALL compute a+b+cin bit-serially, LSB first, one full-add (sum=x^y^c, carry=majority(x,y,c)) per clock.
REQ-015 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; input handshake = in_valid & in_ready.
REQ-017 On input handshake, block SHALL load A/B shift registers, load carry flop with cin, clear bit counter to 0, and enter RUN.
REQ-018 In RUN, each cycle SHALL shift in one sum bit at position counter, update carry flop, and increment counter.
REQ-019 After the cycle processing bit WIDTH-1, FSM SHALL enter DONE; co SHALL equal final carry.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH cycles after the input handshake edge.
REQ-021 In DONE, out_valid=1; sum and co SHALL remain stable until output handshake (out_valid & out_ready).
REQ-022 On output handshake, FSM SHALL return to IDLE; in_ready rises next cycle (no same-cycle accept in DONE).
REQ-023 in_valid while not in IDLE SHALL be ignored; a, b, cin changes outside handshake SHALL not affect result.
REQ-024 out_ready held low SHALL stall in DONE indefinitely with no state change.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and never wrap inside one operation.
REQ-026 sum SHALL show partial results during RUN; consumers SHALL use sum only when out_valid=1.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, busy=0, sum=0, co=0, counter=0, carry flop=0.
REQ-028 rst asserted mid-RUN or in DONE SHALL abort the operation; result SHALL be discarded and never presented.
REQ-029 First input handshake SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output port ovf (1 bit): signed two's-complement overflow = carry into MSB XOR co, valid and held with out_valid, reset 0.
REQ-031 Without SERIAL_ADDER_OVF_EN, port ovf and its carry-into-MSB flop SHALL not exist; all other behaviour identical.

Verification
REQ-032 WIDTH=5, a=5'd13, b=5'd9, cin=0, out_ready=1 -> out_valid at handshake+5 cycles, sum=5'd22, co=0, one-cycle pulse.
REQ-033 a=5'd31, b=5'd1, cin=1 -> sum=5'd1, co=1; with SERIAL_ADDER_OVF_EN: a=5'b01111, b=5'b00001, cin=0 -> sum=5'b10000, ovf=1, co=0.
REQ-034 out_ready=0 for 10 cycles after out_valid, change a/b and pulse in_valid -> sum/co stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-035 rst pulse at RUN cycle 3 -> out_valid never asserts for that operation, in_ready=1 after release, next op a=2,b=3,cin=0 -> sum=5, co=0.
REQ-036 Back-to-back: in_valid held high, out_ready=1, 100 random operand sets -> each result matches a+b+cin, throughput one result per WIDTH+2 cycles.
